sb_rdi_decoder: RTL and testbench

Sideband RX decoder between the sideband deserializer and the RDI/adapter interfaces. It captures 64-bit deserialized sideband packets into an internal FIFO and decodes each header. RDI link-management messages addressed to the PHY produce a message number. D2D adapter messages are forwarded as 32-bit beats under credit and wake control. Malformed packets raise an error pulse.

---
 rtl/sb_rdi_pkg.sv | 86 ++++++++
 rtl/sb_rdi_decoder_if.sv | 34 +++
 rtl/sb_rx_fifo.sv | 45 ++++
 rtl/sb_rdi_decoder.sv | 159 +++++++++++++++
 tb/tb_sb_rdi_decoder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_rdi_pkg.sv
// Shared types and constants for the sideband RX decoder.
// Header field overlay, FSM encoding and RDI message mapping.
package sb_rdi_pkg;

  typedef enum logic [2:0] {
    IDLE             = 3'b000,
    FIFO_READ        = 3'b001,
    DECODING         = 3'b011,
    RDI_MSG          = 3'b010,
    ADAPTER_MSG      = 3'b110,
    ERROR_REPORT     = 3'b111,
    MSG_WITHOUT_DATA = 3'b101,
    MSG_WITH_DATA    = 3'b100
  } state_e;

  localparam logic [4:0] OPC_MSG_NO_DATA = 5'b10010;
  localparam logic [4:0] OPC_MSG_DATA    = 5'b11011;

  localparam logic [2:0] DST_PHY = 3'b110;
  localparam logic [2:0] DST_D2D = 3'b001;

  localparam logic [7:0] MC_REQ = 8'h01;
  localparam logic [7:0] MC_RSP = 8'h02;

  localparam logic [7:0] SC_ACTIVE    = 8'h01;
  localparam logic [7:0] SC_PMNAK     = 8'h02;
  localparam logic [7:0] SC_L1        = 8'h04;
  localparam logic [7:0] SC_L2        = 8'h08;
  localparam logic [7:0] SC_LINKRESET = 8'h09;
  localparam logic [7:0] SC_LINKERROR = 8'h0A;
  localparam logic [7:0] SC_RETRAIN   = 8'h0B;
  localparam logic [7:0] SC_DISABLE   = 8'h0C;

  typedef struct packed {
    logic       dp;
    logic       cp;
    logic [2:0] rsv3;
    logic [2:0] dstid;
    logic [15:0] rsv2;
    logic [7:0] msgsub;
    logic [2:0] srcid;
    logic [6:0] rsv1;
    logic [7:0] msgcode;
    logic [8:0] rsv0;
    logic [4:0] opcode;
  } hdr_t;

  function automatic hdr_t get_hdr(input logic [63:0] w);
    return hdr_t'(w);
  endfunction

  // 0 means the code/subcode pair is not a legal RDI message
  function automatic logic [3:0] rdi_msg_no(
    input logic [7:0] mc,
    input logic [7:0] sc
  );
    logic [3:0] n;
    n = 4'd0;
    if (mc == MC_REQ) begin
      case (sc)
        SC_ACTIVE:    n = 4'd1;
        SC_L1:        n = 4'd2;
        SC_L2:        n = 4'd3;
        SC_LINKRESET: n = 4'd4;
        SC_LINKERROR: n = 4'd5;
        SC_RETRAIN:   n = 4'd6;
        SC_DISABLE:   n = 4'd7;
        default:      n = 4'd0;
      endcase
    end else if (mc == MC_RSP) begin
      case (sc)
        SC_ACTIVE:    n = 4'd8;
        SC_PMNAK:     n = 4'd9;
        SC_L1:        n = 4'd10;
        SC_L2:        n = 4'd11;
        SC_LINKRESET: n = 4'd12;
        SC_LINKERROR: n = 4'd13;
        SC_RETRAIN:   n = 4'd14;
        SC_DISABLE:   n = 4'd15;
        default:      n = 4'd0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sb_rdi_decoder_if.sv
// Deserializer / adapter / RDI signal bundle for the decoder.
// slave = decoder side, master = environment side.
interface sb_rdi_decoder_if;
  logic        i_adapter_is_full;
  logic        i_clk_is_ungated;
  logic        i_adapter_is_waked_up;
  logic        i_deser_done;
  logic [63:0] i_deser_data;
  logic        o_deser_done_sampled;
  logic [31:0] o_pl_cfg;
  logic        o_pl_cfg_vld;
  logic        o_pl_nerror;
  logic        o_wake_adapter;
  logic        o_msg_valid;
  logic [3:0]  o_msg_no;

  modport slave (
    input  i_adapter_is_full, i_clk_is_ungated,
    input  i_adapter_is_waked_up, i_deser_done,
    input  i_deser_data,
    output o_deser_done_sampled, o_pl_cfg,
    output o_pl_cfg_vld, o_pl_nerror,
    output o_wake_adapter, o_msg_valid, o_msg_no
  );

  modport master (
    output i_adapter_is_full, i_clk_is_ungated,
    output i_adapter_is_waked_up, i_deser_done,
    output i_deser_data,
    input  o_deser_done_sampled, o_pl_cfg,
    input  o_pl_cfg_vld, o_pl_nerror,
    input  o_wake_adapter, o_msg_valid, o_msg_no
  );
endinterface

// File: rtl/sb_rx_fifo.sv
// 64-bit synchronous RX FIFO, show-ahead read data.
// Full/empty come from an extra wrap bit on each pointer.
module sb_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        push_i,
  input  logic [63:0] wdata_i,
  input  logic        pop_i,
  output logic [63:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [AW:0] wptr_q, rptr_q;
  logic [63:0] mem_q [FIFO_DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end
endmodule

// File: rtl/sb_rdi_decoder.sv
// Sideband RX decoder: captures deserialized words, decodes headers,
// emits RDI message numbers or forwards adapter beats.
module sb_rdi_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  sb_rdi_decoder_if.slave sb
);
  import sb_rdi_pkg::*;

  logic        done_q, pend_q, ack_q;
  logic        rise, push, pop, full, empty;
  logic [63:0] rdata;

  state_e      state_q;
  logic [63:0] hdr_q, dat_q;
  hdr_t        h;
  logic [3:0]  rdi_no;
  logic [1:0]  beat_q;
  logic        have_q, woken_q;
  logic        cfg_vld_q, nerr_q, wake_q, msg_vld_q;
  logic [31:0] cfg_q;
  logic [3:0]  msg_no_q;
  logic        ready;

  assign rise = sb.i_deser_done & ~done_q;
  assign push = pend_q & ~full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      done_q <= sb.i_deser_done;
      pend_q <= rise | (pend_q & full);
      ack_q  <= push;
    end
  end

  assign pop = (state_q == FIFO_READ) |
               ((state_q == MSG_WITH_DATA) & beat_q[1] &
                ~have_q & ~empty);

  sb_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_i  (push),
    .wdata_i (sb.i_deser_data),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign h      = get_hdr(hdr_q);
  assign rdi_no = rdi_msg_no(h.msgcode, h.msgsub);
  assign ready  = (sb.i_clk_is_ungated | woken_q) &
                  ~sb.i_adapter_is_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      dat_q     <= '0;
      beat_q    <= '0;
      have_q    <= 1'b0;
      woken_q   <= 1'b0;
      cfg_vld_q <= 1'b0;
      cfg_q     <= '0;
      nerr_q    <= 1'b0;
      wake_q    <= 1'b0;
      msg_vld_q <= 1'b0;
      msg_no_q  <= '0;
    end else begin
      cfg_vld_q <= 1'b0;
      nerr_q    <= 1'b0;
      msg_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          woken_q <= 1'b0;
          if (!empty) state_q <= FIFO_READ;
        end
        FIFO_READ: begin
          hdr_q   <= rdata;
          state_q <= DECODING;
        end
        DECODING: begin
          if (h.dstid == DST_PHY && h.opcode == OPC_MSG_NO_DATA &&
              rdi_no != 4'd0)
            state_q <= RDI_MSG;
          else if (h.dstid == DST_D2D &&
                   (h.opcode == OPC_MSG_NO_DATA ||
                    h.opcode == OPC_MSG_DATA))
            state_q <= ADAPTER_MSG;
          else
            state_q <= ERROR_REPORT;
        end
        RDI_MSG: begin
          msg_vld_q <= 1'b1;
          msg_no_q  <= rdi_no;
          state_q   <= IDLE;
        end
        ADAPTER_MSG: begin
          if (sb.i_adapter_is_waked_up) woken_q <= 1'b1;
          // request wake only while the clock is gated and no ack yet
          wake_q <= ~sb.i_clk_is_ungated & ~woken_q &
                    ~sb.i_adapter_is_waked_up;
          if (ready) begin
            beat_q  <= '0;
            state_q <= (h.opcode == OPC_MSG_NO_DATA) ?
                       MSG_WITHOUT_DATA : MSG_WITH_DATA;
          end
        end
        MSG_WITHOUT_DATA: begin
          if (!sb.i_adapter_is_full) begin
            cfg_vld_q <= 1'b1;
            cfg_q     <= beat_q[0] ? hdr_q[63:32] : hdr_q[31:0];
            if (beat_q[0]) state_q <= IDLE;
            else           beat_q  <= beat_q + 2'd1;
          end
        end
        MSG_WITH_DATA: begin
          if (beat_q[1] && !have_q) begin
            if (!empty) begin
              dat_q  <= rdata;
              have_q <= 1'b1;
            end
          end else if (!sb.i_adapter_is_full) begin
            cfg_vld_q <= 1'b1;
            if (beat_q[1])
              cfg_q <= beat_q[0] ? dat_q[63:32] : dat_q[31:0];
            else
              cfg_q <= beat_q[0] ? hdr_q[63:32] : hdr_q[31:0];
            if (beat_q == 2'd3) begin
              have_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        ERROR_REPORT: begin
          nerr_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sb.o_deser_done_sampled = ack_q;
  assign sb.o_pl_cfg             = cfg_q;
  assign sb.o_pl_cfg_vld         = cfg_vld_q;
  assign sb.o_pl_nerror          = nerr_q;
  assign sb.o_wake_adapter       = wake_q;
  assign sb.o_msg_valid          = msg_vld_q;
  assign sb.o_msg_no             = msg_no_q;
endmodule

// File: tb/tb_sb_rdi_decoder.sv
// Scoreboard bench for sb_rdi_decoder: expected output events are
// queued when a word is sent and matched as the DUT emits them.
module tb_sb_rdi_decoder;
  localparam logic [3:0] EV_MSG  = 4'd1;
  localparam logic [3:0] EV_CFG  = 4'd2;
  localparam logic [3:0] EV_NERR = 4'd3;

  logic clk, rst_n;
  int   n_chk, n_fail;
  logic [35:0] exp_q[$];
  logic [35:0] mon_q[$];
  logic [35:0] ev_e;

  sb_rdi_decoder_if bus();

  sb_rdi_decoder #(.FIFO_DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sb      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    mon_q = {};
    if (rst_n) begin
      if (bus.o_msg_valid)
        mon_q.push_back({EV_MSG, 28'd0, bus.o_msg_no});
      if (bus.o_pl_cfg_vld)
        mon_q.push_back({EV_CFG, bus.o_pl_cfg});
      if (bus.o_pl_nerror)
        mon_q.push_back({EV_NERR, 32'd0});
    end
    foreach (mon_q[k]) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%h required=none",
                 mon_q[k]);
      end else begin
        ev_e = exp_q.pop_front();
        if (mon_q[k] !== ev_e) begin
          n_fail++;
          $display("FAIL output_event got=%h required=%h",
                   mon_q[k], ev_e);
        end
      end
    end
  end

  function automatic logic [63:0] mk_hdr(
    input logic [2:0] dst, input logic [4:0] opc,
    input logic [7:0] mc, input logic [7:0] sc
  );
    logic [63:0] w;
    w = '0;
    w[4:0]   = opc;
    w[21:14] = mc;
    w[31:29] = 3'($urandom_range(0, 7));
    w[39:32] = sc;
    w[58:56] = dst;
    w[62]    = 1'($urandom_range(0, 1));
    w[63]    = 1'b1;
    return w;
  endfunction

  task automatic send_word(input logic [63:0] w);
    int t;
    @(posedge clk); #1;
    bus.i_deser_data = w;
    bus.i_deser_done = 1'b1;
    t = 0;
    while (!bus.o_deser_done_sampled && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_chk++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL deser_ack got=timeout required=ack_pulse");
    end
    bus.i_deser_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got=%0d_pending required=0",
               name, exp_q.size());
      exp_q = {};
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic push_beats(input logic [63:0] w);
    exp_q.push_back({EV_CFG, w[31:0]});
    exp_q.push_back({EV_CFG, w[63:32]});
  endtask

  task automatic test_reset();
    logic [40:0] outs;
    @(negedge clk);
    outs = {bus.o_deser_done_sampled, bus.o_pl_cfg, bus.o_pl_cfg_vld,
            bus.o_pl_nerror, bus.o_wake_adapter, bus.o_msg_valid,
            bus.o_msg_no};
    n_chk++;
    if (outs !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h required=0", outs);
    end
  endtask

  task automatic test_rdi_req();
    logic [7:0] sc [7];
    sc = '{8'h01, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({EV_MSG, 28'd0, 4'(i + 1)});
      send_word(mk_hdr(3'b110, 5'b10010, 8'h01, sc[i]));
    end
    wait_drain("rdi_req");
  endtask

  task automatic test_rdi_rsp();
    logic [7:0] sc [8];
    sc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({EV_MSG, 28'd0, 4'(i + 8)});
      send_word(mk_hdr(3'b110, 5'b10010, 8'h02, sc[i]));
    end
    wait_drain("rdi_rsp");
  endtask

  task automatic test_adapter_nodata();
    logic [63:0] w;
    w = mk_hdr(3'b001, 5'b10010, 8'h5A, 8'h33);
    push_beats(w);
    send_word(w);
    wait_drain("adp_nodata");
  endtask

  task automatic test_adapter_data();
    logic [63:0] w, d;
    w = mk_hdr(3'b001, 5'b11011, 8'hA5, 8'h11);
    d = 64'hCAFEBABE_DEADBEEF;
    push_beats(w);
    exp_q.push_back({EV_CFG, 32'hDEADBEEF});
    exp_q.push_back({EV_CFG, 32'hCAFEBABE});
    send_word(w);
    repeat (33) @(posedge clk);
    send_word(d);
    wait_drain("adp_data");
  endtask

  task automatic test_stall();
    logic [63:0] w;
    int vld_cnt;
    w = mk_hdr(3'b001, 5'b10010, 8'h77, 8'h01);
    bus.i_adapter_is_full = 1'b1;
    push_beats(w);
    send_word(w);
    vld_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_pl_cfg_vld) vld_cnt++;
    end
    n_chk++;
    if (vld_cnt != 0) begin
      n_fail++;
      $display("FAIL stall_quiet got=%0d_beats required=0", vld_cnt);
    end
    @(posedge clk); #1;
    bus.i_adapter_is_full = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_wake();
    logic [63:0] w;
    int vld_cnt, t;
    w = mk_hdr(3'b001, 5'b10010, 8'h10, 8'h20);
    bus.i_clk_is_ungated = 1'b0;
    push_beats(w);
    send_word(w);
    vld_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_pl_cfg_vld) vld_cnt++;
    end
    n_chk++;
    if (bus.o_wake_adapter !== 1'b1 || vld_cnt != 0) begin
      n_fail++;
      $display("FAIL wake_req got=wake%b_beats%0d required=wake1_beats0",
               bus.o_wake_adapter, vld_cnt);
    end
    @(posedge clk); #1;
    bus.i_adapter_is_waked_up = 1'b1;
    t = 0;
    while (bus.o_wake_adapter && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (bus.o_wake_adapter !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_drop got=%b required=0", bus.o_wake_adapter);
    end
    @(posedge clk); #1;
    bus.i_adapter_is_waked_up = 1'b0;
    wait_drain("wake");
    bus.i_clk_is_ungated = 1'b1;
  endtask

  task automatic test_error();
    exp_q.push_back({EV_NERR, 32'd0});
    send_word(mk_hdr(3'b011, 5'b10010, 8'h01, 8'h01));
    exp_q.push_back({EV_NERR, 32'd0});
    send_word(mk_hdr(3'b110, 5'b10010, 8'h01, 8'h02));
    exp_q.push_back({EV_NERR, 32'd0});
    send_word(mk_hdr(3'b110, 5'b11011, 8'h01, 8'h01));
    wait_drain("error");
  endtask

  task automatic test_reset_mid();
    logic [40:0] outs;
    bus.i_adapter_is_full = 1'b1;
    bus.i_clk_is_ungated  = 1'b0;
    send_word(mk_hdr(3'b001, 5'b10010, 8'h01, 8'h01));
    send_word(mk_hdr(3'b110, 5'b10010, 8'h01, 8'h04));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    outs = {bus.o_deser_done_sampled, bus.o_pl_cfg, bus.o_pl_cfg_vld,
            bus.o_pl_nerror, bus.o_wake_adapter, bus.o_msg_valid,
            bus.o_msg_no};
    n_chk++;
    if (outs !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%h required=0", outs);
    end
    bus.i_adapter_is_full = 1'b0;
    bus.i_clk_is_ungated  = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    exp_q.push_back({EV_MSG, 28'd0, 4'd13});
    send_word(mk_hdr(3'b110, 5'b10010, 8'h02, 8'h0A));
    wait_drain("reset_mid");
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.i_adapter_is_full     = 1'b0;
    bus.i_clk_is_ungated      = 1'b1;
    bus.i_adapter_is_waked_up = 1'b0;
    bus.i_deser_done          = 1'b0;
    bus.i_deser_data          = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_rdi_req();
    test_rdi_rsp();
    test_adapter_nodata();
    test_adapter_data();
    test_stall();
    test_wake();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
